// File: rtl/audio_tx_pkg.sv
// ----------------------------------------------------------------------------
// audio_tx_pkg
// Shared definitions for the audio serial transmitter:
//   mode_e      - serial format (I2S, left-justified, right-justified)
//   msb_offset  - slot bit position at which a sample's MSB is emitted
// ----------------------------------------------------------------------------
package audio_tx_pkg;

    typedef enum logic [1:0] {
        MODE_I2S = 2'd0,
        MODE_LJ  = 2'd1,
        MODE_RJ  = 2'd2
    } mode_e;

    // I2S delays the MSB one BCK behind the LRCK edge; RJ pushes the
    // sample against the end of the slot.
    function automatic int unsigned msb_offset(
        input mode_e       mode,
        input int unsigned slot_w,
        input int unsigned sample_w
    );
        case (mode)
            MODE_I2S: return 1;
            MODE_LJ:  return 0;
            default:  return slot_w - sample_w;
        endcase
    endfunction

endpackage

// File: rtl/audio_bck_gen.sv
// ----------------------------------------------------------------------------
// audio_bck_gen
// BCK prescaler. Counts 0..BCK_DIV-1 and toggles BCK on terminal count.
// Ports:
//   i_clk, i_rst_n  system clock, async active-low reset
//   i_enable        low holds counter and BCK at reset values
//   o_bck           bit clock (data output, never used as a clock)
//   o_rise, o_fall  one-CLK strobes, high on the edge where BCK rises/falls
// ----------------------------------------------------------------------------
module audio_bck_gen #(
    parameter int unsigned BCK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    output logic o_bck,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CNT_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_bck;
    logic             w_tc;

    assign w_tc = i_enable && (r_cnt == CNT_W'(BCK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_bck <= 1'b0;
        end else if (!i_enable) begin
            r_cnt <= '0;
            r_bck <= 1'b0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_bck <= ~r_bck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bck  = r_bck;
    assign o_rise = w_tc && !r_bck;
    assign o_fall = w_tc &&  r_bck;

endmodule

// File: rtl/audio_serial_tx.sv
// ----------------------------------------------------------------------------
// audio_serial_tx
// Serialises a multi-channel PCM frame onto an I2S / LJ / RJ bus.
// Ports:
//   i_clk, i_rst_n       system clock, async active-low reset
//   i_enable             high = serialiser runs, low = idle (handshake live)
//   i_sample_data        CHANNELS*SAMPLE_W frame, channel 0 in the LSBs
//   i_sample_valid       producer offers i_sample_data
//   o_sample_ready       holding register empty
//   o_i2s_bck            bit clock
//   o_i2s_lrck           word select (0 = first half of slots)
//   o_i2s_data           serial data, MSB first
//   o_underrun           one-CLK pulse when a frame starts without new data
// Data and LRCK update only on BCK falls so they are stable at each BCK rise.
// ----------------------------------------------------------------------------
module audio_serial_tx
    import audio_tx_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned BCK_DIV  = 4,
    parameter mode_e       MODE     = MODE_I2S
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    input  logic [CHANNELS*SAMPLE_W-1:0] i_sample_data,
    input  logic                         i_sample_valid,
    output logic                         o_sample_ready,
    output logic                         o_i2s_bck,
    output logic                         o_i2s_lrck,
    output logic                         o_i2s_data,
    output logic                         o_underrun
);

    localparam int unsigned FRAME_BITS = CHANNELS * SLOT_W;
    localparam int unsigned FRAME_W    = CHANNELS * SAMPLE_W;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned MSB_OFF    = msb_offset(MODE, SLOT_W, SAMPLE_W);

    logic               w_bck;
    logic               w_rise;
    logic               w_fall;

    logic [BIT_W-1:0]   r_bit;
    logic               r_started;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] r_hold;
    logic               r_hold_full;
    logic               r_lrck;
    logic               r_data;
    logic               r_underrun;

    logic [BIT_W-1:0]   w_next_bit;
    logic               w_load;
    logic               w_accept;
    logic [FRAME_W-1:0] w_frame_src;
    logic [31:0]        w_nb;
    logic [31:0]        w_slot;
    logic [31:0]        w_pos;
    logic [31:0]        w_lr_bit;
    logic [31:0]        w_idx;
    logic               w_in_win;
    logic               w_bit_val;
    logic               w_lrck_val;

    audio_bck_gen #(
        .BCK_DIV (BCK_DIV)
    ) u_bck_gen (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .o_bck    (w_bck),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    assign w_next_bit = (r_bit == BIT_W'(FRAME_BITS - 1)) ? '0 : r_bit + 1'b1;
    assign w_load     = w_fall && (w_next_bit == '0);
    assign w_accept   = i_sample_valid && !r_hold_full;
    // A load on this edge uses the holding word as it was before any accept.
    assign w_frame_src = (w_load && r_hold_full) ? r_hold : r_frame;

    always_comb begin
        w_nb      = 32'(w_next_bit);
        w_slot    = w_nb / SLOT_W;
        w_pos     = w_nb % SLOT_W;
        w_in_win  = (w_pos >= MSB_OFF) && (w_pos < MSB_OFF + SAMPLE_W);
        w_idx     = w_slot * SAMPLE_W + SAMPLE_W - 1 - (w_pos - MSB_OFF);
        w_bit_val = 1'b0;
        for (int unsigned k = 0; k < FRAME_W; k++) begin
            if (w_in_win && (k == w_idx)) begin
                w_bit_val = w_frame_src[k];
            end
        end
        // I2S word select leads the slot by one BCK.
        w_lr_bit   = (MODE == MODE_I2S) ? ((w_nb + 1) % FRAME_BITS) : w_nb;
        w_lrck_val = (w_lr_bit / SLOT_W) >= (CHANNELS / 2);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit       <= '0;
            r_started   <= 1'b0;
            r_frame     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_lrck      <= 1'b0;
            r_data      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= w_load && !r_hold_full;

            // Accept only happens with the holding register empty, so it
            // never collides with a load that drains a full holding register.
            if (w_accept) begin
                r_hold      <= i_sample_data;
                r_hold_full <= 1'b1;
            end else if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end

            if (w_load && r_hold_full) begin
                r_frame <= r_hold;
            end

            if (!i_enable) begin
                r_bit     <= '0;
                r_started <= 1'b0;
                r_lrck    <= 1'b0;
                r_data    <= 1'b0;
            end else begin
                // Preset to the last bit on the first rise after enable so the
                // following fall wraps to bit 0 and performs a frame load.
                if (w_rise && !r_started) begin
                    r_bit     <= BIT_W'(FRAME_BITS - 1);
                    r_started <= 1'b1;
                end
                if (w_fall) begin
                    r_bit  <= w_next_bit;
                    r_lrck <= w_lrck_val;
                    r_data <= w_bit_val;
                end
            end
        end
    end

    assign o_sample_ready = !r_hold_full;
    assign o_i2s_bck      = w_bck;
    assign o_i2s_lrck     = r_lrck;
    assign o_i2s_data     = r_data;
    assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_audio_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_audio_serial_tx
// Three instances: A = defaults (I2S, BCK_DIV=1), B = RJ 24-bit samples,
// C = 8 channels LJ with BCK_DIV=2. Serial data and LRCK are captured at
// every BCK rise into per-instance history registers (earliest bit in the
// MSB position of the compared slice).
// ----------------------------------------------------------------------------
module tb_audio_serial_tx;
    import audio_tx_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   en;
    logic [2:0]   vld;
    logic [31:0]  dA;
    logic [47:0]  dB;
    logic [127:0] dC;
    logic [2:0]   rdy, bck, lr, dat, und;

    always #5 clk = ~clk;

    audio_serial_tx #(.SAMPLE_W(16), .SLOT_W(32), .CHANNELS(2), .BCK_DIV(1), .MODE(MODE_I2S)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[0]), .i_sample_data(dA), .i_sample_valid(vld[0]),
        .o_sample_ready(rdy[0]), .o_i2s_bck(bck[0]), .o_i2s_lrck(lr[0]), .o_i2s_data(dat[0]), .o_underrun(und[0]));

    audio_serial_tx #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(2), .BCK_DIV(1), .MODE(MODE_RJ)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[1]), .i_sample_data(dB), .i_sample_valid(vld[1]),
        .o_sample_ready(rdy[1]), .o_i2s_bck(bck[1]), .o_i2s_lrck(lr[1]), .o_i2s_data(dat[1]), .o_underrun(und[1]));

    audio_serial_tx #(.SAMPLE_W(16), .SLOT_W(32), .CHANNELS(8), .BCK_DIV(2), .MODE(MODE_LJ)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[2]), .i_sample_data(dC), .i_sample_valid(vld[2]),
        .o_sample_ready(rdy[2]), .o_i2s_bck(bck[2]), .o_i2s_lrck(lr[2]), .o_i2s_data(dat[2]), .o_underrun(und[2]));

    int unsigned  n_chk = 0;
    int unsigned  n_fail = 0;
    logic [255:0] hd [3];
    logic [255:0] hl [3];
    int unsigned  rises [3];
    int unsigned  unds [3];
    logic [2:0]   pbck;

    localparam logic [63:0] EXP_A1 = {1'b0, 16'hA5A5, 15'h0, 1'b0, 16'h5A5A, 15'h0};
    localparam logic [63:0] EXP_A2 = {1'b0, 16'h8001, 15'h0, 1'b0, 16'h7FFE, 15'h0};
    localparam logic [63:0] LR_I2S = {31'h0, 1'b1, 31'h7FFF_FFFF, 1'b0};
    localparam logic [63:0] EXP_B  = {8'h00, 24'h800001, 8'h00, 24'hC00003};
    localparam logic [63:0] LR_STD = {32'h0, 32'hFFFF_FFFF};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CLK step: sample all instances on the falling CLK edge.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (bck[k] && !pbck[k]) begin
                hd[k] = {hd[k][254:0], dat[k]};
                hl[k] = {hl[k][254:0], lr[k]};
                rises[k]++;
            end
            pbck[k] = bck[k];
            if (und[k]) unds[k]++;
        end
    endtask

    task automatic wait_rises(input int k, input int unsigned n, input string tag);
        int unsigned tgt;
        int unsigned guard;
        tgt = rises[k] + n;
        guard = 0;
        while (rises[k] < tgt && guard < 5000) begin
            tick();
            guard++;
        end
        check(tag, 256'(rises[k] >= tgt), 256'(1));
    endtask

    initial begin
        int unsigned  u;
        logic [255:0] exp_c;

        for (int k = 0; k < 3; k++) begin
            hd[k] = '0; hl[k] = '0; rises[k] = 0; unds[k] = 0;
        end
        pbck = '0;
        exp_c = '0;
        for (int k = 0; k < 8; k++) exp_c[255-32*k -: 32] = {16'(k + 1), 16'h0000};

        en = '0; vld = '0; dA = '0; dB = '0; dC = '0;
        rst_n = 1'b0;
        repeat (3) tick();

        check("rst_bck",   256'(bck), 256'(3'b000));
        check("rst_lrck",  256'(lr),  256'(3'b000));
        check("rst_data",  256'(dat), 256'(3'b000));
        check("rst_und",   256'(und), 256'(3'b000));
        check("rst_ready", 256'(rdy), 256'(3'b111));

        rst_n = 1'b1;
        tick();

        // A: load one frame while idle, then run.
        dA = {16'h5A5A, 16'hA5A5};
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        check("A_ready_drop", 256'(rdy[0]), 256'(0));
        check("A_idle_bck",   256'(bck[0]), 256'(0));

        en[0] = 1'b1;
        u = unds[0];
        wait_rises(0, 65, "A_f0_timeout");
        check("A_f0_data",  256'(hd[0][63:0]), 256'(EXP_A1));
        check("A_f0_lrck",  256'(hl[0][63:0]), 256'(LR_I2S));
        check("A_f0_ready", 256'(rdy[0]), 256'(1));
        check("A_f0_und",   256'(unds[0] - u), 256'(0));

        // Producer stalls: frame repeats, one-cycle underrun.
        u = unds[0];
        wait_rises(0, 64, "A_f1_timeout");
        check("A_f1_repeat", 256'(hd[0][63:0]), 256'(EXP_A1));
        check("A_f1_und",    256'(unds[0] - u), 256'(1));
        check("A_f1_ready",  256'(rdy[0]), 256'(1));

        // Next posedge is the frame-load fall: offer a word on that same edge.
        dA = {16'h7FFE, 16'h8001};
        vld[0] = 1'b1;
        u = unds[0];
        tick();
        vld[0] = 1'b0;
        check("A_same_ready", 256'(rdy[0]), 256'(0));
        check("A_same_und",   256'(unds[0] - u), 256'(1));
        wait_rises(0, 64, "A_f2_timeout");
        check("A_f2_repeat", 256'(hd[0][63:0]), 256'(EXP_A1));
        u = unds[0];
        wait_rises(0, 64, "A_f3_timeout");
        check("A_f3_new",   256'(hd[0][63:0]), 256'(EXP_A2));
        check("A_f3_und",   256'(unds[0] - u), 256'(0));
        check("A_f3_ready", 256'(rdy[0]), 256'(1));

        // Mid-frame reset at bit 47 (R bit1 = 1, LRCK high, BCK high).
        wait_rises(0, 48, "A_f4_timeout");
        check("A_pre_rst", 256'({bck[0], lr[0], dat[0]}), 256'(3'b111));
        rst_n = 1'b0;
        #1;
        check("A_rst_async", 256'({bck[0], lr[0], dat[0], und[0], rdy[0]}), 256'(5'b00001));
        repeat (3) tick();
        rst_n = 1'b1;
        en[0] = 1'b0;
        tick();
        tick();
        check("A_post_idle", 256'({bck[0], lr[0], dat[0]}), 256'(3'b000));
        en[0] = 1'b1;
        u = unds[0];
        wait_rises(0, 65, "A_f5_timeout");
        check("A_f5_zero", 256'(hd[0][63:0]), 256'(0));
        check("A_f5_lrck", 256'(hl[0][63:0]), 256'(LR_I2S));
        check("A_f5_und",  256'(unds[0] - u), 256'(1));

        // B: right-justified 24-bit samples.
        dB = {24'hC00003, 24'h800001};
        vld[1] = 1'b1;
        tick();
        vld[1] = 1'b0;
        check("B_idle_bck", 256'(bck[1]), 256'(0));
        en[1] = 1'b1;
        wait_rises(1, 65, "B_f0_timeout");
        check("B_f0_data", 256'(hd[1][63:0]), 256'(EXP_B));
        check("B_f0_lrck", 256'(hl[1][63:0]), 256'(LR_STD));

        // C: eight left-justified channels carrying 1..8.
        dC = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        vld[2] = 1'b1;
        tick();
        vld[2] = 1'b0;
        en[2] = 1'b1;
        wait_rises(2, 257, "C_f0_timeout");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("C_slot%0d", k), 256'(hd[2][255-32*k -: 32]), 256'({16'(k + 1), 16'h0000}));
        end
        check("C_lrck", hl[2], {{128{1'b0}}, {128{1'b1}}});

        // Abort mid-frame, then restart from bit 0 with a repeated frame.
        wait_rises(2, 40, "C_mid_timeout");
        en[2] = 1'b0;
        tick();
        check("C_abort_idle", 256'({bck[2], lr[2], dat[2]}), 256'(3'b000));
        en[2] = 1'b1;
        u = unds[2];
        wait_rises(2, 257, "C_f1_timeout");
        check("C_restart", hd[2], exp_c);
        check("C_restart_und", 256'(unds[2] - u), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
